// File: rtl/definitions_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : definitions_pkg
//  Description : Shared pixel/window widths and the 3x3 window byte-index
//                convention used by gaussian_window_gen and gaussian_filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package definitions_pkg;

    localparam int PIXEL_W  = 8;
    localparam int WIN_DIM  = 3;
    localparam int WIN_TAPS = WIN_DIM * WIN_DIM;
    localparam int WINDOW_W = WIN_TAPS * PIXEL_W;

    typedef logic [PIXEL_W-1:0]  pixel_t;
    typedef logic [WINDOW_W-1:0] window_t;

    // Byte index of window tap (row, col): row 0 is the oldest line, col 2 the
    // newest column, so index 0 is top-left and index 8 the current pixel.
    function automatic int win_idx(input int row, input int col);
        return row * WIN_DIM + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gaussian_window_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : gaussian_window_gen_if
//  Description : Pixel-in / window-out stream bundle for gaussian_window_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gaussian_window_gen_if;
    import definitions_pkg::*;

    logic [PIXEL_W-1:0]  pixel_in;
    logic                pixel_in_valid;
    logic [WINDOW_W-1:0] window_out;
    logic                window_out_valid;
    logic                frame_done;

    // Producer of pixels / consumer of windows
    modport master (
        output pixel_in, pixel_in_valid,
        input  window_out, window_out_valid, frame_done
    );

    // The window generator itself
    modport slave (
        input  pixel_in, pixel_in_valid,
        output window_out, window_out_valid, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer
//  Description : One-line pixel store. Combinational read of the addressed
//                entry; the write lands on the clock edge, so a read and a
//                write to the same address in one enable cycle return the
//                old contents (read-before-write). No reset on contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer
    import definitions_pkg::*;
#(
    parameter int DEPTH = 512
) (
    input  wire logic                     clk,
    input  wire logic                     en,
    input  wire logic [$clog2(DEPTH)-1:0] addr,
    input  wire pixel_t                   wdata,
    output pixel_t                        rdata
);

    pixel_t mem [DEPTH];

    assign rdata = mem[addr];

    // Store the incoming pixel at the current column on every accepted pixel
    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/gaussian_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : gaussian_window_gen
//  Description : Raster-order pixel stream to 3x3 sliding window. Two line
//                buffers hold lines r-1 and r-2; a 3x3 register shifts one
//                column per accepted pixel. Windows are emitted only for
//                r>=2, c>=2 (no border windows). All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module gaussian_window_gen
    import definitions_pkg::*;
#(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  wire logic            clk,
    input  wire logic            rst,
    gaussian_window_gen_if.slave bus
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(2);

    logic             accept;
    logic             emit;
    logic             last_pixel;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    pixel_t           line1_rd;   // pixel (r-1, c)
    pixel_t           line2_rd;   // pixel (r-2, c)
    pixel_t           win      [WIN_TAPS];
    pixel_t           win_next [WIN_TAPS];
    window_t          win_next_flat;

    // Pixels offered while in reset are dropped
    assign accept     = bus.pixel_in_valid && !rst;
    // Column/row gating keeps stale line-buffer bytes and the two refill
    // columns of each line out of any emitted window
    assign emit       = accept && (row >= ROW_FIRST_WIN) && (col >= COL_FIRST_WIN);
    assign last_pixel = accept && (row == ROW_LAST) && (col == COL_LAST);

    // Line r-1 takes the new pixel; line r-2 takes what line r-1 held there
    line_buffer #(.DEPTH(IMG_WIDTH)) u_line1 (
        .clk   (clk),
        .en    (accept),
        .addr  (col),
        .wdata (bus.pixel_in),
        .rdata (line1_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_line2 (
        .clk   (clk),
        .en    (accept),
        .addr  (col),
        .wdata (line1_rd),
        .rdata (line2_rd)
    );

    // Column/row position of the next accepted pixel, wrapping per line and frame
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Window contents after shifting left one column and loading the new column
    always_comb begin
        for (int i = 0; i < WIN_TAPS; i++) begin
            win_next[i] = win[i];
        end
        for (int wr = 0; wr < WIN_DIM; wr++) begin
            win_next[win_idx(wr, 0)] = win[win_idx(wr, 1)];
            win_next[win_idx(wr, 1)] = win[win_idx(wr, 2)];
        end
        win_next[win_idx(0, 2)] = line2_rd;
        win_next[win_idx(1, 2)] = line1_rd;
        win_next[win_idx(2, 2)] = bus.pixel_in;
    end

    // Pack taps into the shared byte-index layout
    always_comb begin
        win_next_flat = '0;
        for (int i = 0; i < WIN_TAPS; i++) begin
            win_next_flat[i*PIXEL_W +: PIXEL_W] = win_next[i];
        end
    end

    // Shift register for the window; contents only matter once gated by emit
    always_ff @(posedge clk) begin
        if (accept) begin
            win <= win_next;
        end
    end

    // Registered outputs; window_out holds between valid windows
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.window_out       <= '0;
            bus.window_out_valid <= 1'b0;
            bus.frame_done       <= 1'b0;
        end else begin
            bus.window_out_valid <= emit;
            bus.frame_done       <= last_pixel;
            if (emit) begin
                bus.window_out <= win_next_flat;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gaussian_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gaussian_window_gen
//  Description : Directed bench for gaussian_window_gen (5x5 and 3x3 frames).
//                Expected windows come from a 2-D image model and are queued
//                as pixels are driven, then popped as windows appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gaussian_window_gen;
    import definitions_pkg::*;

    localparam int W = 5;
    localparam int H = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gaussian_window_gen_if bus  ();
    gaussian_window_gen_if bus3 ();

    gaussian_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    gaussian_window_gen #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int      vectors    = 0;
    int      miscompares = 0;
    window_t exp_q [$];
    window_t exp_hold;
    pixel_t  img [H][W];
    int      r_m, c_m;
    int      win_cnt;
    window_t first_win, cur_win, tenth_win;

    localparam window_t FIRST_5X5 = 72'h0c0b0a070605020100;
    localparam window_t LAST_5X5  = 72'h1817161312110e0d0c;
    localparam window_t FULL_3X3  = 72'h080706050403020100;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_win(input string tag, input window_t obs, input window_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on the 5x5 DUT, followed by checks of its outputs
    task automatic drive(input pixel_t p, input bit v);
        window_t w;
        bit      ev;
        bit      efd;
        ev  = 1'b0;
        efd = 1'b0;
        w   = '0;
        bus.pixel_in       = p;
        bus.pixel_in_valid = v;
        if (v) begin
            img[r_m][c_m] = p;
            if (r_m >= 2 && c_m >= 2) begin
                for (int wr = 0; wr < 3; wr++)
                    for (int wc = 0; wc < 3; wc++)
                        w[(wr*3+wc)*8 +: 8] = img[r_m-2+wr][c_m-2+wc];
                exp_q.push_back(w);
                exp_hold = w;
                ev = 1'b1;
            end
            efd = (r_m == H-1) && (c_m == W-1);
            if (c_m == W-1) begin
                c_m = 0;
                r_m = (r_m == H-1) ? 0 : r_m + 1;
            end else begin
                c_m = c_m + 1;
            end
        end
        @(posedge clk);
        #1;
        bus.pixel_in_valid = 1'b0;
        check_bit("window_out_valid", bus.window_out_valid, ev);
        check_bit("frame_done", bus.frame_done, efd);
        if (bus.window_out_valid === 1'b1) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("FAIL window_queue observed=unexpected_window expected=none");
            end
            if (exp_q.size() != 0) check_win("window_out", bus.window_out, exp_q.pop_front());
            win_cnt++;
            cur_win = bus.window_out;
            if (win_cnt == 1)  first_win = bus.window_out;
            if (win_cnt == 10) tenth_win = bus.window_out;
        end else begin
            check_win("window_hold", bus.window_out, exp_hold);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.pixel_in       = 8'hAA;
        bus.pixel_in_valid = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.pixel_in_valid = 1'b0;
        check_bit("rst_valid", bus.window_out_valid, 1'b0);
        check_bit("rst_frame_done", bus.frame_done, 1'b0);
        check_win("rst_window", bus.window_out, '0);
        r_m = 0;
        c_m = 0;
        exp_q.delete();
        exp_hold = '0;
        win_cnt  = 0;
    endtask

    task automatic frame(input int base, input int max_gap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (max_gap > 0) begin
                    repeat ($urandom_range(0, max_gap)) drive(8'h00, 1'b0);
                end
                drive(8'(base + W*r + c), 1'b1);
            end
        end
    endtask

    initial begin
        bus3.pixel_in       = '0;
        bus3.pixel_in_valid = 1'b0;

        // Reset with valid asserted, which must be ignored
        do_reset(3);

        // Back-to-back 5x5 frame
        frame(0, 0);
        check_int("b2b_win_count", win_cnt, 9);
        check_win("b2b_first", first_win, FIRST_5X5);
        check_win("b2b_last", cur_win, LAST_5X5);

        // Same frame with random idle gaps
        win_cnt = 0;
        frame(0, 3);
        check_int("gap_win_count", win_cnt, 9);
        check_win("gap_first", first_win, FIRST_5X5);
        check_win("gap_last", cur_win, LAST_5X5);

        // Two frames with no idle cycle between them
        win_cnt = 0;
        frame(0, 0);
        frame(100, 0);
        check_int("two_frame_win_count", win_cnt, 18);
        check_int("tenth_byte0", int'(tenth_win[7:0]), 100);

        // Reset after 13 pixels, then a clean frame
        for (int i = 0; i < 13; i++) drive(8'(200 + i), 1'b1);
        do_reset(1);
        frame(0, 0);
        check_int("post_rst_win_count", win_cnt, 9);
        check_win("post_rst_first", first_win, FIRST_5X5);
        check_win("post_rst_last", cur_win, LAST_5X5);

        // All-ones frame
        win_cnt = 0;
        for (int i = 0; i < W*H; i++) drive(8'hFF, 1'b1);
        check_int("ff_win_count", win_cnt, 9);
        check_win("ff_last", cur_win, {WINDOW_W{1'b1}});

        // 3x3 frame: one window equal to the whole frame, with frame_done
        for (int i = 0; i < 9; i++) begin
            bus3.pixel_in       = 8'(i);
            bus3.pixel_in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus3.pixel_in_valid = 1'b0;
            check_bit("dut3_valid", bus3.window_out_valid, i == 8);
            check_bit("dut3_frame_done", bus3.frame_done, i == 8);
        end
        check_win("dut3_window", bus3.window_out, FULL_3X3);
        @(posedge clk);
        #1;
        check_bit("dut3_valid_after", bus3.window_out_valid, 1'b0);
        check_win("dut3_window_hold", bus3.window_out, FULL_3X3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
